// File: rtl/tlu_emulator_if.sv
// TLU link between the trigger emulator and a readout board.
// The master side drives trigger and reset; the slave side answers
// with busy and the trigger clock used to read out the trigger number.
interface tlu_if;
    logic tlu_trigger;
    logic tlu_reset;
    logic tlu_busy;
    logic tlu_clock;

    modport master (
        output tlu_trigger,
        output tlu_reset,
        input  tlu_busy,
        input  tlu_clock
    );

    modport slave (
        input  tlu_trigger,
        input  tlu_reset,
        output tlu_busy,
        output tlu_clock
    );
endinterface

// File: rtl/tlu_emulator.sv
// Trigger-side model of the EUDET-style TLU handshake.
// On a request it raises TLU_TRIGGER and waits for the DUT's busy.
// It then shifts out the trigger number LSB first, one bit per DUT-driven
// TLU_CLOCK rising edge, and waits for busy to drop before going idle.
// TLU_BUSY and TLU_CLOCK are asynchronous and are synchronised here.
module tlu_emulator #(
    parameter int TRIGGER_NUMBER_BITS = 15,
    parameter int TIMEOUT_CYCLES      = 65535
) (
    input  logic                           clk,
    input  logic                           rst_b,
    input  logic                           enable,
    input  logic                           trigger_req,
    input  logic                           number_reset,
    tlu_if.master                          tlu,
    output logic [TRIGGER_NUMBER_BITS-1:0] trigger_number,
    output logic                           ready,
    output logic                           timeout_err,
    output logic [7:0]                     missed_count
);

    localparam int BW = TRIGGER_NUMBER_BITS;
    localparam int CW = (BW > 1) ? $clog2(BW) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Counter value on the last allowed cycle in a timed state.
    localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [CW-1:0] BIT_LAST = CW'(BW - 1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_WAIT_BUSY    = 2'd1,
        S_SHIFT        = 2'd2,
        S_WAIT_RELEASE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;

    logic            busy_meta_r;
    logic            busy_sync_r;
    logic            tclk_meta_r;
    logic            tclk_sync_r;
    logic            tclk_prev_r;

    logic [BW-1:0]   shift_r;
    logic [BW-1:0]   shift_next_s;
    logic [CW-1:0]   bit_cnt_r;
    logic [CW-1:0]   bit_cnt_next_s;
    logic [TW-1:0]   tcnt_r;
    logic [BW-1:0]   number_r;
    logic [7:0]      missed_r;
    logic [2:0]      rst_left_r;
    logic [2:0]      rst_left_next_s;

    logic            trigger_r;
    logic            trigger_next_s;
    logic            tlu_reset_r;
    logic            ready_r;
    logic            err_r;
    logic            set_err_s;

    logic            tclk_rise_s;
    logic            timeout_s;
    logic            accept_s;

    assign tclk_rise_s = tclk_sync_r & ~tclk_prev_r;
    assign timeout_s   = (TIMEOUT_CYCLES > 0) && (tcnt_r == TO_LAST);
    assign accept_s    = (state_r == S_IDLE) && trigger_req && enable;

    assign tlu.tlu_trigger = trigger_r;
    assign tlu.tlu_reset   = tlu_reset_r;
    assign trigger_number  = number_r;
    assign ready           = ready_r;
    assign timeout_err     = err_r;
    assign missed_count    = missed_r;

    // Two-stage synchronisers for busy and trigger clock, plus a third stage for clock edge detection.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            busy_meta_r <= 1'b0;
            busy_sync_r <= 1'b0;
            tclk_meta_r <= 1'b0;
            tclk_sync_r <= 1'b0;
            tclk_prev_r <= 1'b0;
        end else begin
            busy_meta_r <= tlu.tlu_busy;
            busy_sync_r <= busy_meta_r;
            tclk_meta_r <= tlu.tlu_clock;
            tclk_sync_r <= tclk_meta_r;
            tclk_prev_r <= tclk_sync_r;
        end
    end

    // Handshake next-state logic, shift/bit counter update and next trigger line value.
    always_comb begin
        state_next_s   = state_r;
        shift_next_s   = shift_r;
        bit_cnt_next_s = bit_cnt_r;
        set_err_s      = 1'b0;
        trigger_next_s = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = S_WAIT_BUSY;
                    shift_next_s = number_r;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WAIT_BUSY: begin
                if (busy_sync_r) begin
                    state_next_s   = S_SHIFT;
                    bit_cnt_next_s = '0;
                end else if (timeout_s) begin
                    state_next_s = S_IDLE;
                    set_err_s    = 1'b1;
                end else begin
                    state_next_s = S_WAIT_BUSY;
                end
            end
            S_SHIFT: begin
                // A clock edge wins over a simultaneous busy drop so the bit is not lost.
                if (tclk_rise_s) begin
                    shift_next_s   = shift_r >> 1;
                    bit_cnt_next_s = bit_cnt_r + CW'(1);
                    if (bit_cnt_r == BIT_LAST) begin
                        state_next_s = S_WAIT_RELEASE;
                    end else begin
                        state_next_s = S_SHIFT;
                    end
                end else if (!busy_sync_r) begin
                    state_next_s = S_IDLE;
                end else if (timeout_s) begin
                    state_next_s = S_IDLE;
                    set_err_s    = 1'b1;
                end else begin
                    state_next_s = S_SHIFT;
                end
            end
            S_WAIT_RELEASE: begin
                if (!busy_sync_r) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_WAIT_RELEASE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase

        // Trigger line is registered from the next state so it never glitches.
        case (state_next_s)
            S_IDLE:         trigger_next_s = 1'b0;
            S_WAIT_BUSY:    trigger_next_s = 1'b1;
            S_SHIFT:        trigger_next_s = shift_next_s[0];
            S_WAIT_RELEASE: trigger_next_s = 1'b0;
            default:        trigger_next_s = 1'b0;
        endcase

        if (number_reset) begin
            rst_left_next_s = 3'd4;
        end else if (rst_left_r != 3'd0) begin
            rst_left_next_s = rst_left_r - 3'd1;
        end else begin
            rst_left_next_s = 3'd0;
        end
    end

    // State register, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r     <= S_IDLE;
            shift_r     <= '0;
            bit_cnt_r   <= '0;
            tcnt_r      <= '0;
            number_r    <= '0;
            missed_r    <= 8'd0;
            rst_left_r  <= 3'd0;
            trigger_r   <= 1'b0;
            tlu_reset_r <= 1'b0;
            ready_r     <= 1'b1;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            shift_r     <= shift_next_s;
            bit_cnt_r   <= bit_cnt_next_s;
            trigger_r   <= trigger_next_s;
            ready_r     <= (state_next_s == S_IDLE);
            rst_left_r  <= rst_left_next_s;
            tlu_reset_r <= (rst_left_next_s != 3'd0);

            // Timeout counter restarts on every state change and every trigger clock edge.
            if ((state_next_s != state_r) || tclk_rise_s || (TIMEOUT_CYCLES == 0)) begin
                tcnt_r <= '0;
            end else begin
                tcnt_r <= tcnt_r + TW'(1);
            end

            // Number reset has priority over the post-accept increment.
            if (number_reset) begin
                number_r <= '0;
            end else if (accept_s) begin
                number_r <= number_r + BW'(1);
            end else begin
                number_r <= number_r;
            end

            if (number_reset) begin
                err_r <= 1'b0;
            end else if (set_err_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end

            if (number_reset) begin
                missed_r <= 8'd0;
            end else if (trigger_req && !accept_s && (missed_r != 8'hFF)) begin
                missed_r <= missed_r + 8'd1;
            end else begin
                missed_r <= missed_r;
            end
        end
    end

endmodule

// File: tb/tb_tlu_emulator.sv
// Bench for tlu_emulator: the bench plays the readout board (busy and
// trigger clock) and keeps an abstract model of trigger number, missed
// requests and the error flag.
module tb_tlu_emulator;

    localparam int B   = 5;
    localparam int TO  = 100;
    localparam int MOD = 1 << B;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         enable;
    logic         trigger_req;
    logic         number_reset;
    logic [B-1:0] trigger_number;
    logic         ready;
    logic         timeout_err;
    logic [7:0]   missed_count;

    tlu_if link();

    tlu_emulator #(.TRIGGER_NUMBER_BITS(B), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .enable         (enable),
        .trigger_req    (trigger_req),
        .number_reset   (number_reset),
        .tlu            (link),
        .trigger_number (trigger_number),
        .ready          (ready),
        .timeout_err    (timeout_err),
        .missed_count   (missed_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_num  = 0;
    int exp_missed = 0;
    int exp_err  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag, input int limit);
        int n;
        n = 0;
        while (!ready && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(ready), 32'd1);
    endtask

    task automatic check_status();
        chk("trigger_number", 32'(trigger_number), exp_num);
        chk("missed_count", 32'(missed_count), exp_missed);
        chk("timeout_err", 32'(timeout_err), exp_err);
    endtask

    task automatic miss_inc();
        if (exp_missed < 255) exp_missed++;
    endtask

    // Standalone number reset in IDLE; expects a 4-cycle TLU_RESET pulse.
    task automatic do_number_reset();
        int rcnt;
        number_reset = 1'b1;
        @(negedge clk);
        number_reset = 1'b0;
        exp_num = 0; exp_missed = 0; exp_err = 0;
        rcnt = int'(link.tlu_reset);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rcnt += int'(link.tlu_reset);
        end
        chk("nreset_pulse_len", 32'(rcnt), 32'd4);
        chk("nreset_pulse_end", 32'(link.tlu_reset), 32'd0);
        check_status();
    endtask

    // Request while disabled: dropped and counted.
    task automatic disabled_request();
        enable = 1'b0;
        trigger_req = 1'b1;
        @(negedge clk);
        trigger_req = 1'b0;
        enable = 1'b1;
        miss_inc();
        chk("disabled_ready", 32'(ready), 32'd1);
        check_status();
    endtask

    // One trigger handshake as seen by the readout board.
    // abort_at >= 0 drops busy after that many bits have been clocked.
    task automatic handshake(input bit nres, input int miss_pulses, input int abort_at);
        int exp_word, word, rcnt;
        exp_word = exp_num;
        if (nres) begin
            exp_num = 0; exp_missed = 0; exp_err = 0;
        end else begin
            exp_num = (exp_num + 1) % MOD;
        end
        enable = 1'b1;
        trigger_req = 1'b1;
        number_reset = nres;
        @(negedge clk);
        trigger_req = 1'b0;
        number_reset = 1'b0;
        chk("accept_trigger_high", 32'(link.tlu_trigger), 32'd1);
        chk("accept_not_ready", 32'(ready), 32'd0);
        chk("accept_number", 32'(trigger_number), exp_num);
        rcnt = int'(link.tlu_reset);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rcnt += int'(link.tlu_reset);
        end
        chk("tlu_reset_len", 32'(rcnt), nres ? 32'd4 : 32'd0);
        chk("wait_busy_trigger_high", 32'(link.tlu_trigger), 32'd1);

        link.tlu_busy = 1'b1;
        tick(4 + int'($urandom_range(0, 4)));
        word = 0;
        for (int i = 0; i < B; i++) begin
            if (i == abort_at) break;
            word |= int'(link.tlu_trigger) << i;
            if (i < miss_pulses) begin
                trigger_req = 1'b1;
                @(negedge clk);
                trigger_req = 1'b0;
                miss_inc();
            end
            link.tlu_clock = 1'b1;
            tick(4 + int'($urandom_range(0, 4)));
            link.tlu_clock = 1'b0;
            tick(4 + int'($urandom_range(0, 4)));
        end

        if (abort_at >= 0 && abort_at < B) begin
            chk("abort_partial_word", 32'(word), 32'(exp_word & ((1 << abort_at) - 1)));
            link.tlu_busy = 1'b0;
            wait_ready("abort_ready", 10);
            chk("abort_trigger_low", 32'(link.tlu_trigger), 32'd0);
        end else begin
            chk("release_trigger_low", 32'(link.tlu_trigger), 32'd0);
            chk("release_not_ready", 32'(ready), 32'd0);
            tick(int'($urandom_range(0, 6)));
            link.tlu_busy = 1'b0;
            wait_ready("release_ready", 10);
            chk("serial_word", 32'(word), 32'(exp_word));
        end
        check_status();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, op;
        rst_b = 1'b0;
        enable = 1'b0;
        trigger_req = 1'b0;
        number_reset = 1'b0;
        link.tlu_busy = 1'b0;
        link.tlu_clock = 1'b0;
        tick(3);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_trigger", 32'(link.tlu_trigger), 32'd0);
        chk("rst_tlu_reset", 32'(link.tlu_reset), 32'd0);
        check_status();
        rst_b = 1'b1;
        enable = 1'b1;
        tick(2);
        chk("post_rst_ready", 32'(ready), 32'd1);
        chk("post_rst_trigger", 32'(link.tlu_trigger), 32'd0);

        // Basic trigger: sixth handshake carries number 5.
        for (int i = 0; i < 6; i++) handshake(1'b0, 0, -1);
        chk("basic_number_6", 32'(trigger_number), 32'd6);

        // Missed requests: three during SHIFT, one while disabled.
        do_number_reset();
        handshake(1'b0, 3, -1);
        disabled_request();
        chk("missed_is_4", 32'(missed_count), 32'd4);

        // Number reset together with an accepted request at number 9.
        do_number_reset();
        for (int i = 0; i < 9; i++) handshake(1'b0, 0, -1);
        chk("pre_nres_number_9", 32'(trigger_number), 32'd9);
        handshake(1'b1, 0, -1);
        chk("nres_number_0", 32'(trigger_number), 32'd0);

        // Wrap: the 32nd handshake after reset carries all ones.
        for (int i = 0; i < MOD; i++) handshake(1'b0, 0, -1);
        chk("wrap_number_0", 32'(trigger_number), 32'd0);

        // Randomised mix of operations.
        for (int i = 0; i < 30; i++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 5)      handshake(1'b0, int'($urandom_range(0, 2)), -1);
            else if (op == 6) handshake(1'b0, 0, int'($urandom_range(0, B - 1)));
            else if (op == 7) disabled_request();
            else if (op == 8) do_number_reset();
            else              handshake(1'b1, 0, -1);
        end

        // Timeout: busy never answers.
        enable = 1'b1;
        trigger_req = 1'b1;
        @(negedge clk);
        trigger_req = 1'b0;
        exp_num = (exp_num + 1) % MOD;
        exp_err = 1;
        n = 1;
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'(TO + 1));
        chk("timeout_trigger_low", 32'(link.tlu_trigger), 32'd0);
        check_status();
        handshake(1'b0, 0, -1);

        // Asynchronous reset in the middle of SHIFT.
        disabled_request();
        trigger_req = 1'b1;
        @(negedge clk);
        trigger_req = 1'b0;
        link.tlu_busy = 1'b1;
        tick(6);
        link.tlu_clock = 1'b1;
        tick(5);
        link.tlu_clock = 1'b0;
        tick(5);
        chk("mid_shift_not_ready", 32'(ready), 32'd0);
        #2;
        rst_b = 1'b0;
        #1;
        exp_num = 0; exp_missed = 0; exp_err = 0;
        chk("async_rst_ready", 32'(ready), 32'd1);
        chk("async_rst_trigger", 32'(link.tlu_trigger), 32'd0);
        chk("async_rst_tlu_reset", 32'(link.tlu_reset), 32'd0);
        check_status();
        @(negedge clk);
        link.tlu_busy = 1'b0;
        rst_b = 1'b1;
        tick(5);
        chk("after_rst_ready", 32'(ready), 32'd1);
        handshake(1'b0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
